// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed symmetric FIR: one pre-adder, one multiplier, one accumulator
// Define FIR_SATURATE_EN to clamp the output instead of two's-complement wrapping.
module fir_mac_sequencer #(
   parameter int DW        = 8,
   parameter int TAPS      = 15,
   parameter int CW        = 17,
   parameter int OUT_SHIFT = 21
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic signed [DW-1:0]          in_data,
   output logic                          in_ready,
   input  logic                          coef_we,
   input  logic [$clog2((TAPS+1)/2)-1:0] coef_addr,
   input  logic signed [CW-1:0]          coef_wdata,
   output logic                          coef_err,
   output logic                          out_valid,
   output logic signed [DW-1:0]          out_data,
   output logic                          overrun
);
   localparam int NC    = (TAPS+1)/2;
   localparam int AW    = $clog2(NC);
   localparam int PW    = $clog2(TAPS);
   localparam int MW    = DW+1+CW;
   localparam int ACC_W = DW+1+CW+$clog2(NC);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                  state;
   logic signed [DW-1:0]    ring [TAPS];
   logic signed [CW-1:0]    coef [NC];
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           ia;
   logic [PW-1:0]           ib;
   logic [AW-1:0]           step;
   logic signed [ACC_W-1:0] acc;
   logic signed [DW:0]      pre;
   logic signed [MW-1:0]    prod;
   logic signed [DW-1:0]    y;

   function automatic logic signed [CW-1:0] default_coef(input int i);
      case (i)
         0:       default_coef = CW'(5241);
         1:       default_coef = CW'(8226);
         2:       default_coef = CW'(16590);
         3:       default_coef = CW'(28678);
         4:       default_coef = CW'(42095);
         5:       default_coef = CW'(54183);
         6:       default_coef = CW'(62549);
         7:       default_coef = CW'(65535);
         default: default_coef = '0;
      endcase
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(TAPS-1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? PW'(TAPS-1) : p - PW'(1);
   endfunction

   assign in_ready = (state == IDLE);

   // ia walks back from the newest sample, ib forward from the oldest; they meet at the centre tap.
   always_comb begin
      pre = (DW+1)'(ring[ia]);
      if (step != AW'(NC-1))
         pre = pre + (DW+1)'(ring[ib]);
      prod = MW'(pre) * MW'(coef[step]);
   end

`ifdef FIR_SATURATE_EN
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2**(DW-1))-1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
   logic signed [ACC_W-1:0] shifted;
   always_comb begin
      shifted = acc >>> OUT_SHIFT;
      if (shifted > Y_MAX)
         y = Y_MAX[DW-1:0];
      else if (shifted < Y_MIN)
         y = Y_MIN[DW-1:0];
      else
         y = shifted[DW-1:0];
   end
`else
   assign y = acc[OUT_SHIFT+DW-1:OUT_SHIFT];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         ia        <= '0;
         ib        <= '0;
         step      <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         coef_err  <= 1'b0;
         overrun   <= 1'b0;
         for (int i = 0; i < TAPS; i++) ring[i] <= '0;
         for (int i = 0; i < NC; i++) coef[i] <= default_coef(i);
      end else begin
         out_valid <= 1'b0;
         coef_err  <= 1'b0;
         overrun   <= in_valid && (state != IDLE);
         if (coef_we) begin
            if (state == IDLE && int'(coef_addr) < NC)
               coef[coef_addr] <= coef_wdata;
            else
               coef_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ring[wr_ptr] <= in_data;
                  ia           <= wr_ptr;
                  ib           <= ptr_inc(wr_ptr);
                  wr_ptr       <= ptr_inc(wr_ptr);
                  acc          <= '0;
                  step         <= '0;
                  state        <= MAC;
               end
            end
            MAC: begin
               acc  <= acc + ACC_W'(prod);
               ia   <= ptr_dec(ia);
               ib   <= ptr_inc(ib);
               step <= step + AW'(1);
               if (step == AW'(NC-1))
                  state <= DONE;
            end
            DONE: begin
               out_data  <= y;
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - scoreboard bench for fir_mac_sequencer against a direct-form FIR model
// Honours FIR_SATURATE_EN the same way the design does.
module tb_fir_mac_sequencer;
   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic signed [7:0] in_data;
   logic              in_ready;
   logic              coef_we;
   logic [2:0]        coef_addr;
   logic signed [16:0] coef_wdata;
   logic              coef_err;
   logic              out_valid;
   logic signed [7:0] out_data;
   logic              overrun;

   int total = 0;
   int bad   = 0;

   logic signed [7:0] hist [15];
   int                cm [8];
   logic signed [7:0] exp_q [$];
   logic signed [7:0] mon_exp;

   fir_mac_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
      .out_valid(out_valid), .out_data(out_data), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 15; i++) hist[i] = '0;
      cm[0] = 5241;  cm[1] = 8226;  cm[2] = 16590; cm[3] = 28678;
      cm[4] = 42095; cm[5] = 54183; cm[6] = 62549; cm[7] = 65535;
   endtask

   function automatic logic signed [7:0] model_y();
      longint a = 0;
      int k;
      for (int i = 0; i < 15; i++) begin
         k = (i < 8) ? i : 14 - i;
         a += longint'(hist[i]) * longint'(cm[k]);
      end
      a = a >>> 21;
`ifdef FIR_SATURATE_EN
      if (a > 127) a = 127;
      else if (a < -128) a = -128;
`endif
      return a[7:0];
   endfunction

   task automatic push_sample(input logic signed [7:0] d);
      for (int i = 14; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = d;
      exp_q.push_back(model_y());
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output out_data=%0d required=no output", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
               bad++;
               $display("FAIL out_data got=%0d required=%0d", out_data, mon_exp);
            end
         end
      end
   end

   task automatic send(input logic signed [7:0] d);
      int g = 0;
      while (!in_ready && g < 40) begin
         @(posedge clk); #1; g++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      push_sample(d);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total += 5;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
      if (out_data !== 8'sd0) begin bad++; $display("FAIL reset_out_data got=%0d required=0", out_data); end
      if (coef_err !== 1'b0) begin bad++; $display("FAIL reset_coef_err got=%0b required=0", coef_err); end
      if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b required=0", overrun); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_impulse();
      int lat = 0;
      send(8'sd127);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = c; break; end
      end
      total++;
      if (lat !== 9) begin bad++; $display("FAIL impulse_latency got=%0d required=9", lat); end
      for (int i = 0; i < 14; i++) send(8'sd0);
      drain();
   endtask

   task automatic test_dc_step();
      for (int i = 0; i < 16; i++) send(8'sd100);
      drain();
      total++;
      if (out_data !== 8'sd23) begin bad++; $display("FAIL dc_pos got=%0d required=23", out_data); end
      for (int i = 0; i < 16; i++) send(-8'sd100);
      drain();
      total++;
      if (out_data !== -8'sd24) begin bad++; $display("FAIL dc_neg got=%0d required=-24", out_data); end
   endtask

   task automatic test_overrun();
      int ov = 0;
      int acc_n = 0;
      logic rdy;
      logic signed [7:0] d;
      for (int c = 0; c < 30; c++) begin
         d = 8'($urandom_range(0, 255));
         in_data = d; in_valid = 1'b1; rdy = in_ready;
         @(posedge clk);
         if (rdy) begin acc_n++; push_sample(d); end
         #1;
         if (overrun) ov++;
      end
      in_valid = 1'b0;
      total += 2;
      if (acc_n !== 3) begin bad++; $display("FAIL overrun_accepts got=%0d required=3", acc_n); end
      if (ov !== 27) begin bad++; $display("FAIL overrun_pulses got=%0d required=27", ov); end
      drain();
   endtask

   task automatic test_coef_write();
      for (int a = 0; a < 8; a++) begin
         coef_we = 1'b1; coef_addr = 3'(a); coef_wdata = 17'sd65535;
         @(posedge clk);
         cm[a] = 65535;
         #1;
         coef_we = 1'b0;
         total++;
         if (coef_err !== 1'b0) begin bad++; $display("FAIL coef_idle_err addr=%0d got=%0b required=0", a, coef_err); end
      end
      for (int i = 0; i < 16; i++) send(8'sd127);
      drain();
      total++;
      if (out_data !== 8'sd59) begin bad++; $display("FAIL coef_all_max got=%0d required=59", out_data); end
      send(8'sd127);
      coef_we = 1'b1; coef_addr = 3'd3; coef_wdata = '0;
      @(posedge clk); #1;
      coef_we = 1'b0;
      total++;
      if (coef_err !== 1'b1) begin bad++; $display("FAIL coef_busy_err got=%0b required=1", coef_err); end
      drain();
      in_valid = 1'b1; in_data = -8'sd50;
      coef_we = 1'b1; coef_addr = 3'd7; coef_wdata = 17'sd1000;
      @(posedge clk);
      cm[7] = 1000;
      push_sample(-8'sd50);
      #1;
      in_valid = 1'b0; coef_we = 1'b0;
      total++;
      if (coef_err !== 1'b0) begin bad++; $display("FAIL coef_with_accept_err got=%0b required=0", coef_err); end
      send(8'sd5);
      drain();
   endtask

   task automatic test_reset_mid_mac();
      int seen = 0;
      send(8'sd90);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(exp_q.pop_back());
      model_reset();
      total += 2;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%0b required=1", in_ready); end
      if (out_data !== 8'sd0) begin bad++; $display("FAIL abort_out_data got=%0d required=0", out_data); end
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL abort_out_valid got=%0d required=0", seen); end
      test_impulse();
   endtask

   task automatic test_ring_wrap();
      for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)));
      drain();
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_dc_step();
      test_overrun();
      test_coef_write();
      test_reset_mid_mac();
      test_ring_wrap();
      total++;
      if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d required=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
